spi_txn_scheduler: RTL and testbench
====================================

Name: spi_txn_scheduler

Overview:
- SPI master-side scheduler that shares one SPI bus between two requesters, each targeting its own slave select.
- Arbitrates requests round-robin and owns the chip selects.
- Generates SCLK from clk through a divider and shifts one DATA_W-bit word full-duplex, MSB first, SPI mode 0.
- Returns the captured MISO word to the winning requester with a done pulse.

Parameters:
- DATA_W, 16, transaction word width in bits.
- CLK_DIV, 2, clk cycles per SCLK half-period. Legal range 1..255; any other value is an elaboration error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  2  req[i] requests one transaction from requester i; level, held until ack[i]
- tx_data0  in  DATA_W  word to send for requester 0; sampled on ack[0]
- tx_data1  in  DATA_W  word to send for requester 1; sampled on ack[1]
- ack  out  2  one-cycle pulse: request accepted, tx word latched
- done  out  2  one-cycle pulse: transaction of requester i complete, rx_data valid
- rx_data  out  DATA_W  last word captured from MISO
- owner  out  1  index of current or last granted requester
- busy  out  1  high whenever state != IDLE
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data to slaves
- miso  in  1  serial data from selected slave
- cs_n  out  2  active-low slave selects; at most one bit low at any time

Behaviour:
- Reset values: ack=0, done=0, rx_data=0, owner=1, busy=0, sclk=0, mosi=0, cs_n=2'b11, state=IDLE, bit_cnt=0, div_cnt=0.
- Reset asserted mid-transaction aborts at once: cs_n releases, no done is issued, and the aborted requester must re-request.
- States:
  - IDLE: no transaction. cs_n=11, sclk=0.
  - SETUP: CLK_DIV cycles, selected cs_n low, sclk low, mosi=bit DATA_W-1.
  - SHIFT: 2*DATA_W SCLK half-periods of CLK_DIV cycles each.
  - HOLD: CLK_DIV cycles, sclk low, cs_n still low.
- Arbitration (IDLE only, evaluated every cycle):
  - Only one request high: grant it.
  - Both high: grant !owner (round-robin). After reset, owner=1, so requester 0 wins the first tie.
- Grant edge: ack[winner]=1 for one cycle, owner<=winner, tx shift reg<=tx_data[winner], cs_n[winner]<=0, state->SETUP.
- SHIFT timing:
  - div_cnt counts 0..CLK_DIV-1; at terminal count sclk toggles.
  - Rising edge: rx shift reg <= {rx[DATA_W-2:0], miso}, bit_cnt++.
  - Falling edge: if bit_cnt==DATA_W, go to HOLD; otherwise shift tx left and drive mosi with the new MSB.
- Leaving HOLD: cs_n<=11, rx_data<=rx shift reg, done[owner]=1 for one cycle, state->IDLE.
- The minimum cs_n-high gap between transactions is 1 cycle, because arbitration happens in IDLE.
- Latency: done rises exactly (2*DATA_W+2)*CLK_DIV cycles after ack rises (68 for the defaults).
- Requests:
  - A request dropped before ack is ignored and never granted.
  - req is not sampled outside IDLE; a request asserted during another's transaction waits and is granted on IDLE entry.
  - A requester whose req is still high the cycle after its own done gets back-to-back service only when the other requester's req is low.
- tx_data changes after ack have no effect on the transaction in flight.
- rx_data holds its value until the next done.
- CLK_DIV=1: sclk toggles every cycle; all rules above still apply.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD)
  - DATA_W default
  - NUM_REQ=2
  - CS_IDLE=2'b11 constant
- Sub-module spi_sclk_gen: divider with enable, producing sclk plus one-cycle rise_stb/fall_stb strobes. It is cleared whenever the scheduler is outside SHIFT.

Test Plan:
- Single request: req=01, tx_data0=16'hA5C3, slave loops back mosi->miso. Expect ack[0] at cycle 1, cs_n=10, 16 sclk rising edges, done[0] 68 cycles after ack, rx_data=16'hA5C3.
- Simultaneous requests: req=11 out of reset with tx_data0=16'h1234, tx_data1=16'hBEEF. Expect requester 0 served first, then requester 1 with ≥1 cycle cs_n=11 gap. Done order is 0 then 1; rx_data=16'h1234, then 16'hBEEF.
- Round-robin fairness: hold req=11 for 4 transactions. Expect owner sequence 0,1,0,1 and ack/done counts of 2 per requester.
- MISO capture: miso driven from fixed pattern 16'h8001 on sclk falling edges, tx_data1=16'h0000. Expect rx_data=16'h8001 and mosi constant 0.
- Reset mid-transaction: assert reset at the 8th sclk rising edge. Expect cs_n=11, sclk=0, busy=0 immediately, and no done pulse. After release, a re-request completes normally.
- CLK_DIV=1 build: req=10, tx_data1=16'hFFFF with loopback. Expect done[1] 34 cycles after ack and rx_data=16'hFFFF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
`timescale 1ns/1ps
package spi_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_REQ = 2;
  localparam logic [NUM_REQ-1:0] CS_IDLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled cycles and flags the
// cycle before each edge so the scheduler can act on the same clk edge.
`timescale 1ns/1ps
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  logic [7:0] div_cnt;
  logic       tc;

  assign tc       = en && (div_cnt == 8'(CLK_DIV - 1));
  assign rise_stb = tc && !sclk;
  assign fall_stb = tc && sclk;

  // Disabling clears the divider so every SHIFT phase starts from a clean half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/spi_txn_scheduler.sv
// Two-requester SPI master: round-robin arbitration, chip-select ownership,
// and one full-duplex MSB-first mode-0 word transfer per grant.
`timescale 1ns/1ps
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  tx_data0,
  input  logic [DATA_W-1:0]  tx_data1,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] done,
  output logic [DATA_W-1:0]  rx_data,
  output logic               owner,
  output logic               busy,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic [NUM_REQ-1:0] cs_n,
  output spi_state_e         dbg_state
);
  localparam int BW = $clog2(DATA_W + 1);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_txn_scheduler: CLK_DIV must be in 1..255");
  end

  spi_state_e        state;
  logic [BW-1:0]     bit_cnt;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              rise_stb;
  logic              fall_stb;
  logic              winner;
  logic [DATA_W-1:0] tx_sel;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (state == SHIFT),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    winner = owner;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~owner;
      default: winner = owner;
    endcase
    tx_sel = winner ? tx_data1 : tx_data0;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ack      <= '0;
      done     <= '0;
      rx_data  <= '0;
      owner    <= 1'b1;
      mosi     <= 1'b0;
      cs_n     <= CS_IDLE;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            ack      <= NUM_REQ'(1) << winner;
            owner    <= winner;
            tx_sr    <= tx_sel;
            mosi     <= tx_sel[DATA_W-1];
            cs_n     <= ~(NUM_REQ'(1) << winner);
            bit_cnt  <= '0;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (wait_cnt == 8'(CLK_DIV - 1)) begin
            wait_cnt <= '0;
            state    <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (rise_stb) begin
            rx_sr   <= {rx_sr[DATA_W-2:0], miso};
            bit_cnt <= bit_cnt + BW'(1);
          end
          // The falling edge after the last capture ends the shift phase.
          if (fall_stb) begin
            if (bit_cnt == BW'(DATA_W)) begin
              state <= HOLD;
            end else begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[DATA_W-2];
            end
          end
        end
        HOLD: begin
          if (wait_cnt == 8'(CLK_DIV - 1)) begin
            wait_cnt <= '0;
            cs_n     <= CS_IDLE;
            rx_data  <= rx_sr;
            done     <= NUM_REQ'(1) << owner;
            mosi     <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler: a CLK_DIV=2 instance driven from a
// vector table plus hand sequences, and a CLK_DIV=1 instance for timing.
`timescale 1ns/1ps
module tb_spi_txn_scheduler;
  import spi_pkg::*;
  localparam int DW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A (CLK_DIV = 2)
  logic [1:0]    req;
  logic [DW-1:0] tx_data0, tx_data1;
  logic [1:0]    ack, done, cs_n;
  logic [DW-1:0] rx_data;
  logic          owner, busy, sclk, mosi, miso;
  spi_state_e    dbg_state;

  // DUT B (CLK_DIV = 1), looped back
  logic [1:0]    req_b;
  logic [DW-1:0] tx0_b, tx1_b;
  logic [1:0]    ack_b, done_b, cs_n_b;
  logic [DW-1:0] rx_b;
  logic          owner_b, busy_b, sclk_b, mosi_b, miso_b;
  spi_state_e    state_b;

  spi_txn_scheduler #(.DATA_W(DW), .CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .req(req), .tx_data0(tx_data0), .tx_data1(tx_data1),
    .ack(ack), .done(done), .rx_data(rx_data), .owner(owner), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .dbg_state(dbg_state)
  );

  spi_txn_scheduler #(.DATA_W(DW), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .tx_data0(tx0_b), .tx_data1(tx1_b),
    .ack(ack_b), .done(done_b), .rx_data(rx_b), .owner(owner_b), .busy(busy_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b), .dbg_state(state_b)
  );
  assign miso_b = mosi_b;

  // slave model for DUT A: loopback, or a fixed word shifted out on sclk falls
  logic          loopback;
  logic [DW-1:0] miso_pat;
  int            miso_idx = 0;
  logic          cs_idle;
  assign cs_idle = &cs_n;
  always @(negedge sclk or posedge cs_idle) begin
    if (cs_idle) miso_idx <= 0;
    else         miso_idx <= miso_idx + 1;
  end
  assign miso = loopback ? mosi : ((miso_idx < DW) ? miso_pat[DW-1-miso_idx] : 1'b0);

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [DW-1:0] tx0;
    logic [DW-1:0] tx1;
    logic          loopback;
    logic [DW-1:0] pat;
    logic [DW-1:0] exp_rx;
    logic          mosi_zero;
  } vec_t;
  vec_t vecs[5];

  // driver tasks
  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == 2'b00 && cyc < 20);
  endtask

  task automatic wait_done(output int lat, output int rises, output logic saw_one);
    logic prev;
    lat = 0; rises = 0; saw_one = mosi; prev = sclk;
    do begin
      @(negedge clk);
      lat++;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (mosi && done == 2'b00) saw_one = 1'b1;
    end while (done == 2'b00 && lat < 300);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, lat, rises;
    logic saw_one;
    logic [1:0] exp_cs;
    exp_cs = ~v.req;
    @(negedge clk);
    req = v.req; tx_data0 = v.tx0; tx_data1 = v.tx1;
    loopback = v.loopback; miso_pat = v.pat;
    exp_q.push_back(v.exp_rx);
    wait_ack(cyc);
    chk({tag, "_ack_lat"}, cyc, 1);
    chk({tag, "_ack"}, ack, v.req);
    chk({tag, "_owner"}, owner, v.req[1]);
    chk({tag, "_cs_sel"}, cs_n, exp_cs);
    req = 2'b00;
    tx_data0 = ~v.tx0;
    tx_data1 = ~v.tx1;
    wait_done(lat, rises, saw_one);
    chk({tag, "_latency"}, lat, 68);
    chk({tag, "_done"}, done, v.req);
    chk({tag, "_rises"}, rises, 16);
    chk({tag, "_cs_rel"}, cs_n, 2'b11);
    chk({tag, "_rx"}, rx_data, exp_q.pop_front());
    if (v.mosi_zero) chk({tag, "_mosi0"}, saw_one, 1'b0);
  endtask

  initial begin
    int cyc, lat, rises, ack_cnt0, ack_cnt1, done_cnt0, done_cnt1;
    logic saw_one, prev, saw_done;

    vecs[0] = '{2'b01, 16'hA5C3, 16'h0000, 1'b1, 16'h0000, 16'hA5C3, 1'b0};
    vecs[1] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h8001, 16'h8001, 1'b1};
    vecs[2] = '{2'b01, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'hFFFF, 1'b0};
    vecs[3] = '{2'b10, 16'h0000, 16'h5A0F, 1'b1, 16'h0000, 16'h5A0F, 1'b0};
    vecs[4] = '{2'b01, 16'h0001, 16'hFFFF, 1'b1, 16'h0000, 16'h0001, 1'b0};

    reset = 1'b1; req = 2'b00; tx_data0 = '0; tx_data1 = '0;
    loopback = 1'b1; miso_pat = '0;
    req_b = 2'b00; tx0_b = '0; tx1_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_rx", rx_data, 16'h0000);
    chk("rst_owner", owner, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cs", cs_n, 2'b11);
    chk("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // simultaneous requests out of reset: 0 first, then 1
    @(negedge clk);
    req = 2'b11; tx_data0 = 16'h1234; tx_data1 = 16'hBEEF;
    wait_ack(cyc);
    chk("sim_ack0", ack, 2'b01);
    chk("sim_owner0", owner, 1'b0);
    chk("sim_busy", busy, 1'b1);
    req = 2'b10;
    wait_done(lat, rises, saw_one);
    chk("sim_done0", done, 2'b01);
    chk("sim_rx0", rx_data, 16'h1234);
    chk("sim_gap", cs_n, 2'b11);
    wait_ack(cyc);
    chk("sim_ack1_lat", cyc, 1);
    chk("sim_ack1", ack, 2'b10);
    chk("sim_cs1", cs_n, 2'b01);
    req = 2'b00;
    wait_done(lat, rises, saw_one);
    chk("sim_done1", done, 2'b10);
    chk("sim_rx1", rx_data, 16'hBEEF);

    // round-robin with both requests held
    ack_cnt0 = 0; ack_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    @(negedge clk);
    req = 2'b11; tx_data0 = 16'h1111; tx_data1 = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      wait_ack(cyc);
      ack_cnt0 += int'(ack[0]); ack_cnt1 += int'(ack[1]);
      chk($sformatf("rr_owner%0d", k), owner, k[0]);
      wait_done(lat, rises, saw_one);
      done_cnt0 += int'(done[0]); done_cnt1 += int'(done[1]);
      if (k == 3) req = 2'b00;
    end
    chk("rr_ack0", ack_cnt0, 2);
    chk("rr_ack1", ack_cnt1, 2);
    chk("rr_done0", done_cnt0, 2);
    chk("rr_done1", done_cnt1, 2);

    // table-driven single requests
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // rx_data holds after done
    repeat (5) @(negedge clk);
    chk("rx_hold", rx_data, 16'h0001);

    // reset at the 8th sclk rising edge aborts with no done
    @(negedge clk);
    req = 2'b01; tx_data0 = 16'h3C3C; loopback = 1'b1;
    wait_ack(cyc);
    chk("abort_ack", ack, 2'b01);
    req = 2'b00;
    rises = 0; prev = sclk; cyc = 0;
    while (rises < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("abort_rises", rises, 8);
    reset = 1'b1;
    #1;
    chk("abort_cs", cs_n, 2'b11);
    chk("abort_sclk", sclk, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_state", dbg_state, IDLE);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    reset = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done != 2'b00) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);
    chk("abort_rx_clr", rx_data, 16'h0000);
    run_vec('{2'b01, 16'h3C3C, 16'h0000, 1'b1, 16'h0000, 16'h3C3C, 1'b0}, "rereq");

    // CLK_DIV = 1 instance
    @(negedge clk);
    req_b = 2'b10; tx1_b = 16'hFFFF;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack_b == 2'b00 && cyc < 20);
    chk("div1_ack", ack_b, 2'b10);
    chk("div1_cs", cs_n_b, 2'b01);
    req_b = 2'b00; tx1_b = 16'h0000;
    lat = 0; rises = 0; prev = sclk_b;
    do begin
      @(negedge clk);
      lat++;
      if (sclk_b && !prev) rises++;
      prev = sclk_b;
    end while (done_b == 2'b00 && lat < 300);
    chk("div1_latency", lat, 34);
    chk("div1_done", done_b, 2'b10);
    chk("div1_rises", rises, 16);
    chk("div1_rx", rx_b, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
